// File: rtl/pingpong_mem_ctrl_if.sv
// Butterfly-side bus of the ping-pong FFT memory: swap control, dual write/read ports and status.
// The sequencer drives the master modport; pingpong_mem_ctrl takes the slave modport.
interface pingpong_mem_ctrl_if #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned NUM_STAGES = 4
);
    localparam int unsigned STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic               swap;
    logic               wr_en;
    logic [ADDR_W-1:0]  wa_1;
    logic [ADDR_W-1:0]  wa_2;
    logic [DATA_W-1:0]  wd_1;
    logic [DATA_W-1:0]  wd_2;
    logic               rd_en;
    logic [ADDR_W-1:0]  ra_1;
    logic [ADDR_W-1:0]  ra_2;
    logic [DATA_W-1:0]  rd_1;
    logic [DATA_W-1:0]  rd_2;
    logic               rd_valid;
    logic               sel;
    logic [STAGE_W-1:0] stage;
    logic               frame_done;
    logic               wr_collide;

    modport master (
        output swap, wr_en, wa_1, wa_2, wd_1, wd_2, rd_en, ra_1, ra_2,
        input  rd_1, rd_2, rd_valid, sel, stage, frame_done, wr_collide
    );

    modport slave (
        input  swap, wr_en, wa_1, wa_2, wd_1, wd_2, rd_en, ra_1, ra_2,
        output rd_1, rd_2, rd_valid, sel, stage, frame_done, wr_collide
    );
endinterface

// File: rtl/pingpong_mem_ctrl.sv
// Ping-pong dual-bank butterfly memory: bank select, stage counter and frame completion.
// Optional PINGPONG_COLLIDE_DETECT_EN builds a sticky same-address write flag.
module pingpong_mem_ctrl #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned NUM_STAGES = 4
) (
    input logic                clk,
    input logic                rst,
    pingpong_mem_ctrl_if.slave bus
);
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

    logic [DATA_W-1:0]  bankA [0:DEPTH-1];
    logic [DATA_W-1:0]  bankB [0:DEPTH-1];

    logic               selQ;
    logic [STAGE_W-1:0] stageQ;
    logic               frameDoneQ;
    logic               rdValidQ;
    logic [DATA_W-1:0]  rdData1Q;
    logic [DATA_W-1:0]  rdData2Q;
    logic               wrCollideQ;

    // Write bank is A when sel=0; port 2 is written last so it wins on equal addresses.
    always_ff @(posedge clk) begin
        if (!rst && bus.wr_en) begin
            if (!selQ) begin
                bankA[bus.wa_1] <= bus.wd_1;
                bankA[bus.wa_2] <= bus.wd_2;
            end else begin
                bankB[bus.wa_1] <= bus.wd_1;
                bankB[bus.wa_2] <= bus.wd_2;
            end
        end
    end

    // Read bank is the opposite of the write bank; data holds when no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdValidQ <= 1'b0;
            rdData1Q <= '0;
            rdData2Q <= '0;
        end else begin
            rdValidQ <= bus.rd_en;
            if (bus.rd_en) begin
                if (selQ) begin
                    rdData1Q <= bankA[bus.ra_1];
                    rdData2Q <= bankA[bus.ra_2];
                end else begin
                    rdData1Q <= bankB[bus.ra_1];
                    rdData2Q <= bankB[bus.ra_2];
                end
            end
        end
    end

    // Each swap toggles the banks and advances the stage; leaving the last stage ends the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            selQ       <= 1'b0;
            stageQ     <= '0;
            frameDoneQ <= 1'b0;
        end else if (bus.swap) begin
            selQ <= ~selQ;
            if (stageQ == STAGE_LAST) begin
                stageQ     <= '0;
                frameDoneQ <= 1'b1;
            end else begin
                stageQ     <= stageQ + STAGE_W'(1);
                frameDoneQ <= 1'b0;
            end
        end else begin
            frameDoneQ <= 1'b0;
        end
    end

`ifdef PINGPONG_COLLIDE_DETECT_EN
    // Sticky until reset so a single bad address pair from the generator is never missed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrCollideQ <= 1'b0;
        end else if (bus.wr_en && (bus.wa_1 == bus.wa_2)) begin
            wrCollideQ <= 1'b1;
        end
    end
`else
    assign wrCollideQ = 1'b0;
`endif

    assign bus.sel        = selQ;
    assign bus.stage      = stageQ;
    assign bus.frame_done = frameDoneQ;
    assign bus.rd_valid   = rdValidQ;
    assign bus.rd_1       = rdData1Q;
    assign bus.rd_2       = rdData2Q;
    assign bus.wr_collide = wrCollideQ;
endmodule
